first_nios2_system_sysid_master: RTL and testbench
==================================================

FIRST_NIOS2_SYSTEM_SYSID_MASTER -- requirements
Module: first_nios2_system_sysid_master

Interface
REQ-001 SHALL provide parameter EXPECTED_ID, default 0, 32-bit system ID expected at slave address 0.
REQ-002 SHALL provide parameter EXPECTED_TS, default 1433944346, 32-bit timestamp expected at slave address 1.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 255, range 1..65535, maximum consecutive waitrequest cycles tolerated per read.
REQ-004 SHALL have port clock, input, 1, the single rising-edge clock for all logic.
REQ-005 SHALL have port reset, input, 1; one clock, reset asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, single-cycle request to run one check sequence.
REQ-007 SHALL have port address, output, 1, Avalon-MM word address to the sysid slave.
REQ-008 SHALL have port read, output, 1, Avalon-MM read strobe.
REQ-009 SHALL have port waitrequest, input, 1, slave stall; tie low for the zero-wait sysid slave.
REQ-010 SHALL have port readdata, input, 32, slave read data, valid in the cycle read=1 and waitrequest=0.
REQ-011 SHALL have outputs busy, done, id_ok, ts_ok and timeout, each 1 bit: status flags.
REQ-012 SHALL have outputs id_value and ts_value, each 32 bits: captured read data.

Function
REQ-013 SHALL implement the states IDLE, RD_ID, RD_TS and DONE.
REQ-014 IDLE or DONE with start=1 SHALL move to RD_ID on the next edge, clear done/id_ok/ts_ok/timeout, and keep id_value/ts_value until overwritten.
REQ-015 RD_ID SHALL drive read=1 and address=0; RD_TS SHALL drive read=1 and address=1; all other states SHALL drive read=0 and address=0.
REQ-016 Registered outputs SHALL hold read, address and state stable while waitrequest=1, per the Avalon-MM rule.
REQ-017 RD_ID with waitrequest=0 SHALL capture readdata into id_value and move to RD_TS, so there is no idle cycle between the two reads.
REQ-018 RD_TS with waitrequest=0 SHALL capture readdata into ts_value and move to DONE.
REQ-019 Entering DONE normally SHALL set done=1, id_ok=(id_value==EXPECTED_ID) and ts_ok=(ts_value==EXPECTED_TS), all in the same cycle.
REQ-020 Flags SHALL hold until the next accepted start.
REQ-021 Nominal latency with waitrequest=0 SHALL be 3 edges from the start edge to done=1.
REQ-022 busy SHALL be 1 exactly in RD_ID and RD_TS.
REQ-023 start while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-024 A 16-bit wait counter SHALL clear on entry to each read state and increment on every cycle with waitrequest=1.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES with waitrequest still 1, the block SHALL move to DONE with done=1, timeout=1, id_ok=0 and ts_ok=0, and deassert read.
REQ-026 waitrequest=0 in the same cycle the count reaches TIMEOUT_CYCLES SHALL count as success; accepted data takes priority over timeout.
REQ-027 start asserted in DONE SHALL restart the sequence exactly as it does from IDLE.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, read=0, address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0 and wait counter=0.
REQ-029 Reset mid-read SHALL abandon the transaction with no partial capture.
REQ-030 The first state change SHALL occur on the first clock edge after reset deasserts.

Configuration
REQ-031 With macro SYSID_MASTER_AUTOSTART_EN defined, the block SHALL behave as if start=1 on the first edge after reset release: RD_ID in that cycle, with no start pulse needed.
REQ-032 With SYSID_MASTER_AUTOSTART_EN defined, the start port SHALL still trigger later checks as usual.
REQ-033 With SYSID_MASTER_AUTOSTART_EN undefined, the block SHALL remain in IDLE until start=1.

Verification
REQ-034 Zero-wait slave returning 0 at addr 0 and 1433944346 at addr 1, one start pulse -> read for 2 cycles (addr 0, then 1), done=1 on the 3rd edge, id_ok=1, ts_ok=1, timeout=0.
REQ-035 Same slave, EXPECTED_TS=1433944347 -> done=1, id_ok=1, ts_ok=0, ts_value=1433944346.
REQ-036 waitrequest=1 for 4 cycles on addr 1, TIMEOUT_CYCLES=255 -> read and address stay stable 4 cycles, then normal completion with ts_ok=1.
REQ-037 waitrequest held 1, TIMEOUT_CYCLES=8 -> after 8 stall cycles in RD_ID: done=1, timeout=1, id_ok=0, read=0, RD_TS never entered.
REQ-038 reset pulsed during RD_TS, then start -> all outputs 0 during reset, fresh sequence passes; with SYSID_MASTER_AUTOSTART_EN defined, the check runs with no start pulse.
REQ-039 start pulsed every cycle while busy -> exactly one sequence completes; start in DONE -> flags clear and a second sequence runs.

Source files
------------

// File: rtl/first_nios2_system_sysid_master.sv
// Avalon-MM master that reads the sysid slave (ID at word 0, timestamp at word 1) and flags matches.
// Optional SYSID_MASTER_AUTOSTART_EN launches one check on the first edge after reset release.
module first_nios2_system_sysid_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1433944346,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {StIdle, StRdId, StRdTs, StDone} state_e;

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        go;

`ifdef SYSID_MASTER_AUTOSTART_EN
  // High only for the first cycle after reset release.
  logic auto_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= 1'b0;
    end
  end
  assign go = start | auto_q;
`else
  assign go = start;
`endif

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    done_d       = done_q;
    id_ok_d      = id_ok_q;
    ts_ok_d      = ts_ok_q;
    timeout_d    = timeout_q;
    id_value_d   = id_value_q;
    ts_value_d   = ts_value_q;
    wait_cnt_inc = wait_cnt_q + 16'd1;

    case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d    = StRdId;
          wait_cnt_d = 16'd0;
          done_d     = 1'b0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      StRdId, StRdTs: begin
        // Accepted data wins over a timeout landing in the same cycle.
        if (!waitrequest) begin
          wait_cnt_d = 16'd0;
          if (state_q == StRdId) begin
            id_value_d = readdata;
            state_d    = StRdTs;
          end else begin
            ts_value_d = readdata;
            state_d    = StDone;
            done_d     = 1'b1;
            id_ok_d    = (id_value_q == EXPECTED_ID);
            ts_ok_d    = (readdata == EXPECTED_TS);
          end
        end else if (wait_cnt_inc == TimeoutLimit) begin
          wait_cnt_d = wait_cnt_inc;
          state_d    = StDone;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 16'd0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Bus strobes decode straight from the state register, so they hold while stalled.
  assign read     = (state_q == StRdId) || (state_q == StRdTs);
  assign address  = (state_q == StRdTs);
  assign busy     = read;
  assign done     = done_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_master.sv
// Scoreboard bench: two instances (default, and EXPECTED_TS+1 / TIMEOUT_CYCLES=8) share one slave stimulus.
module tb_first_nios2_system_sysid_master;

  localparam logic [31:0] TS = 32'd1433944346;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
  } exp_t;

  logic        clock, reset, start, wr;
  logic        addr_a, rd_a, busy_a, done_a, idok_a, tsok_a, to_a;
  logic        addr_b, rd_b, busy_b, done_b, idok_b, tsok_b, to_b;
  logic [31:0] idv_a, tsv_a, idv_b, tsv_b, rdata_a, rdata_b;
  logic        done_pa, done_pb;
  int          tests_run, tests_failed;
  exp_t        q_a[$], q_b[$];

  assign rdata_a = addr_a ? TS : 32'd0;
  assign rdata_b = addr_b ? TS : 32'd0;

  first_nios2_system_sysid_master dut_a (
    .clock(clock), .reset(reset), .start(start), .address(addr_a), .read(rd_a),
    .waitrequest(wr), .readdata(rdata_a), .busy(busy_a), .done(done_a), .id_ok(idok_a),
    .ts_ok(tsok_a), .timeout(to_a), .id_value(idv_a), .ts_value(tsv_a)
  );

  first_nios2_system_sysid_master #(
    .EXPECTED_TS(32'd1433944347),
    .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start), .address(addr_b), .read(rd_b),
    .waitrequest(wr), .readdata(rdata_b), .busy(busy_b), .done(done_b), .id_ok(idok_b),
    .ts_ok(tsok_b), .timeout(to_b), .id_value(idv_b), .ts_value(tsv_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string who, input exp_t e, input logic io, input logic tso,
                         input logic to, input logic [31:0] iv, input logic [31:0] tv);
    check({who, ".id_ok"}, {31'd0, io}, {31'd0, e.id_ok});
    check({who, ".ts_ok"}, {31'd0, tso}, {31'd0, e.ts_ok});
    check({who, ".timeout"}, {31'd0, to}, {31'd0, e.timeout});
    check({who, ".id_value"}, iv, e.id_value);
    check({who, ".ts_value"}, tv, e.ts_value);
  endtask

  // Monitor: each rising done pops the oldest expected result.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done_a && !done_pa) begin
      if (q_a.size() == 0) check("a.unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        compare("a", e, idok_a, tsok_a, to_a, idv_a, tsv_a);
      end
    end
    if (!reset && done_b && !done_pb) begin
      if (q_b.size() == 0) check("b.unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        compare("b", e, idok_b, tsok_b, to_b, idv_b, tsv_b);
      end
    end
    done_pa <= done_a;
    done_pb <= done_b;
  end

  task automatic push_a(input logic io, input logic tso, input logic to,
                        input logic [31:0] iv, input logic [31:0] tv);
    exp_t e;
    e.id_ok = io; e.ts_ok = tso; e.timeout = to; e.id_value = iv; e.ts_value = tv;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic io, input logic tso, input logic to,
                        input logic [31:0] iv, input logic [31:0] tv);
    exp_t e;
    e.id_ok = io; e.ts_ok = tso; e.timeout = to; e.id_value = iv; e.ts_value = tv;
    q_b.push_back(e);
  endtask

  task automatic push_pass();
    push_a(1'b1, 1'b1, 1'b0, 32'd0, TS);
    push_b(1'b1, 1'b0, 1'b0, 32'd0, TS);
  endtask

  // Returns at the negedge after the start edge (both DUTs then in RD_ID).
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_both_idle(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (!busy_a && !busy_b) return;
    end
    check({name, ".wait_bound"}, 32'd1, 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, ".a_bus"}, {29'd0, rd_a, addr_a, busy_a}, 32'd0);
    check({name, ".a_flags"}, {28'd0, done_a, idok_a, tsok_a, to_a}, 32'd0);
    check({name, ".a_values"}, idv_a | tsv_a, 32'd0);
    check({name, ".b_bus"}, {29'd0, rd_b, addr_b, busy_b}, 32'd0);
    check({name, ".b_flags"}, {28'd0, done_b, idok_b, tsok_b, to_b}, 32'd0);
    check({name, ".b_values"}, idv_b | tsv_b, 32'd0);
  endtask

  task automatic release_reset(input string name);
    @(negedge clock);
    reset = 1'b0;
`ifdef SYSID_MASTER_AUTOSTART_EN
    push_pass();
    wait_both_idle({name, ".autostart"}, 20);
`else
    repeat (2) @(negedge clock);
    check({name, ".stays_idle"}, {30'd0, busy_a, busy_b}, 32'd0);
`endif
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b1; start = 1'b0; wr = 1'b0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    release_reset("rel1");

    // Nominal: addr 0 then addr 1, done on the third edge.
    push_pass();
    pulse_start();
    check("nom.e1", {29'd0, rd_a, addr_a, busy_a}, 32'b101);
    @(negedge clock);
    check("nom.e2", {29'd0, rd_a, addr_a, busy_a}, 32'b111);
    @(negedge clock);
    check("nom.e3", {29'd0, rd_a, done_a, busy_a}, 32'b010);
    wait_both_idle("nom", 5);

    // Four stall cycles on the timestamp read.
    push_pass();
    pulse_start();
    @(negedge clock);
    wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall.hold", {29'd0, rd_a, addr_a, done_a}, 32'b110);
    end
    wr = 1'b0;
    wait_both_idle("stall", 5);

    // Seven stalls on ID read: b accepts just before its 8-cycle limit.
    push_pass();
    pulse_start();
    wr = 1'b1;
    repeat (7) @(negedge clock);
    check("edge.b_still_reading", {30'd0, rd_b, done_b}, 32'b10);
    wr = 1'b0;
    wait_both_idle("edge", 5);

    // Timeout: b after 8 stalls in RD_ID, a after 255; values kept from before.
    push_a(1'b0, 1'b0, 1'b1, 32'd0, TS);
    push_b(1'b0, 1'b0, 1'b1, 32'd0, TS);
    pulse_start();
    wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("to.b_rd_id", {30'd0, rd_b, addr_b}, 32'b10);
      @(negedge clock);
    end
    check("to.b_done", {29'd0, done_b, rd_b, to_b}, 32'b101);
    wait_both_idle("to", 300);
    wr = 1'b0;

    // Start held while busy: exactly one sequence.
    push_pass();
    @(negedge clock);
    start = 1'b1;
    repeat (2) @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("spam.one_seq", {29'd0, busy_a, done_a, idok_a}, 32'b011);
    check("spam.queue", q_a.size(), 32'd0);

    // Restart from DONE clears flags.
    push_pass();
    pulse_start();
    check("restart.cleared", {28'd0, done_a, idok_a, tsok_a, busy_a}, 32'b0001);
    wait_both_idle("restart", 5);

    // Reset during RD_TS abandons the read.
    pulse_start();
    @(negedge clock);
    check("mid.in_rd_ts", {30'd0, rd_a, addr_a}, 32'b11);
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    release_reset("rel2");
    push_pass();
    pulse_start();
    wait_both_idle("fresh", 5);

    repeat (2) @(negedge clock);
    check("end.queue_a", q_a.size(), 32'd0);
    check("end.queue_b", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
